// File: rtl/bpsk_mod.sv
// bpsk_mod: serialises DW-bit words MSB first and BPSK-modulates each bit
// onto a 64-sample sine carrier. Each bit lasts one symbol of 128 clocks,
// with symbol boundaries marked by rising edges of the upstream clk1.
module bpsk_mod #(
   parameter int DW = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [6:0]          count,
   input  logic                clk1,
   input  logic [DW-1:0]       din,
   input  logic                din_valid,
   output logic                din_ready,
   output logic signed [7:0]   bpsk_out,
   output logic                tx_bit,
   output logic                sym_active,
   output logic                byte_done
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state_r;
   logic                   clk1_d_r;
   logic [DW-1:0]          hold_r;
   logic                   hold_empty_r;
   logic [DW-1:0]          shift_r;
   logic [CW-1:0]          bit_cnt_r;
   logic                   tx_bit_r;
   logic signed [7:0]      bpsk_r;
   logic                   byte_done_r;
   logic                   sym_active_r;

   logic                   strobe_s;
   logic                   accept_s;
   logic                   load_s;
   logic [DW-1:0]          shift_nxt_s;
   logic signed [7:0]      carrier_s;
   logic signed [7:0]      mod_s;

   // count[6] belongs to the upstream counter's symbol half; only the phase bits are used here
   logic                   count_unused_s;
   assign count_unused_s = count[6];

   // First quadrant of round(127*sin(2*pi*k/64)), k = 0..16
   function automatic logic [6:0] quarter_sine(input logic [4:0] idx);
      case (idx)
         5'd0:    quarter_sine = 7'd0;
         5'd1:    quarter_sine = 7'd12;
         5'd2:    quarter_sine = 7'd25;
         5'd3:    quarter_sine = 7'd37;
         5'd4:    quarter_sine = 7'd49;
         5'd5:    quarter_sine = 7'd60;
         5'd6:    quarter_sine = 7'd71;
         5'd7:    quarter_sine = 7'd81;
         5'd8:    quarter_sine = 7'd90;
         5'd9:    quarter_sine = 7'd98;
         5'd10:   quarter_sine = 7'd106;
         5'd11:   quarter_sine = 7'd112;
         5'd12:   quarter_sine = 7'd117;
         5'd13:   quarter_sine = 7'd122;
         5'd14:   quarter_sine = 7'd125;
         5'd15:   quarter_sine = 7'd126;
         5'd16:   quarter_sine = 7'd127;
         default: quarter_sine = 7'd0;
      endcase
   endfunction

   // Full 64-entry carrier built from the quadrant table by mirror and sign symmetry
   function automatic logic signed [7:0] carrier_lut(input logic [5:0] k);
      logic [4:0] m;
      logic [6:0] mag;
      if (k[4]) begin
         m = 5'd16 - {1'b0, k[3:0]};
      end else begin
         m = {1'b0, k[3:0]};
      end
      mag = quarter_sine(m);
      if (k[5]) begin
         carrier_lut = -$signed({1'b0, mag});
      end else begin
         carrier_lut = $signed({1'b0, mag});
      end
   endfunction

   // Symbol strobe, input handshake, word-load decode and modulated sample
   always_comb begin
      strobe_s    = clk1 & ~clk1_d_r;
      accept_s    = din_valid & hold_empty_r;
      shift_nxt_s = {shift_r[DW-2:0], 1'b0};
      if (strobe_s && !hold_empty_r &&
          ((state_r == IDLE) || ((state_r == RUN) && (bit_cnt_r == LAST_BIT)))) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
      carrier_s = carrier_lut(count[5:0]);
      // +/-127 is the largest magnitude, so negation cannot overflow
      if (tx_bit_r) begin
         mod_s = -carrier_s;
      end else begin
         mod_s = carrier_s;
      end
   end

   // Delayed copy of clk1 for rising-edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk1_d_r <= 1'b0;
      end else begin
         clk1_d_r <= clk1;
      end
   end

   // Holding register: filled by the handshake, emptied when the FSM loads it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_r       <= {DW{1'b0}};
         hold_empty_r <= 1'b1;
      end else if (accept_s) begin
         hold_r       <= din;
         hold_empty_r <= 1'b0;
      end else if (load_s) begin
         hold_empty_r <= 1'b1;
      end else begin
         hold_empty_r <= hold_empty_r;
      end
   end

   // Symbol sequencer: loads words, shifts bits out on each strobe, flags word end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r      <= IDLE;
         shift_r      <= {DW{1'b0}};
         bit_cnt_r    <= {CW{1'b0}};
         tx_bit_r     <= 1'b0;
         byte_done_r  <= 1'b0;
         sym_active_r <= 1'b0;
      end else begin
         byte_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (load_s) begin
                  shift_r      <= hold_r;
                  tx_bit_r     <= hold_r[DW-1];
                  bit_cnt_r    <= {CW{1'b0}};
                  state_r      <= RUN;
                  sym_active_r <= 1'b1;
               end else begin
                  state_r      <= IDLE;
                  sym_active_r <= 1'b0;
               end
            end
            RUN: begin
               if (strobe_s) begin
                  if (bit_cnt_r != LAST_BIT) begin
                     shift_r   <= shift_nxt_s;
                     tx_bit_r  <= shift_nxt_s[DW-1];
                     bit_cnt_r <= bit_cnt_r + CNT_ONE;
                  end else begin
                     byte_done_r <= 1'b1;
                     if (load_s) begin
                        // Next word follows immediately, no gap symbol
                        shift_r   <= hold_r;
                        tx_bit_r  <= hold_r[DW-1];
                        bit_cnt_r <= {CW{1'b0}};
                     end else begin
                        state_r      <= IDLE;
                        sym_active_r <= 1'b0;
                     end
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            default: begin
               state_r      <= IDLE;
               sym_active_r <= 1'b0;
            end
         endcase
      end
   end

   // Output sample uses the bit held before this edge, so a new bit shows one cycle after its strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bpsk_r <= 8'sd0;
      end else if (state_r == RUN) begin
         bpsk_r <= mod_s;
      end else begin
         bpsk_r <= 8'sd0;
      end
   end

   assign din_ready  = hold_empty_r;
   assign bpsk_out   = bpsk_r;
   assign tx_bit     = tx_bit_r;
   assign sym_active = sym_active_r;
   assign byte_done  = byte_done_r;

endmodule

// File: tb/tb_bpsk_mod.sv
// tb_bpsk_mod: directed bench for bpsk_mod with a bit-queue scoreboard.
// Accepted words push their bits; each symbol strobe pops the bit expected on tx_bit.
module tb_bpsk_mod;

   logic              clk;
   logic              reset_n;
   logic [6:0]        count;
   logic              clk1;
   logic [7:0]        din;
   logic              din_valid;
   logic              din_ready;
   logic signed [7:0] bpsk_out;
   logic              tx_bit;
   logic              sym_active;
   logic              byte_done;

   int checks = 0;
   int errors = 0;

   // scoreboard / reference state
   bit mdl_q[$];
   bit mdl_run   = 1'b0;
   bit mdl_bit   = 1'b0;
   int mdl_pos   = 0;
   bit mdl_ready = 1'b1;
   bit clk1_prev = 1'b0;

   logic [6:0] ucnt = 7'd0;

   bpsk_mod #(.DW(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .count      (count),
      .clk1       (clk1),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .bpsk_out   (bpsk_out),
      .tx_bit     (tx_bit),
      .sym_active (sym_active),
      .byte_done  (byte_done)
   );

   assign count = ucnt;
   assign clk1  = ucnt[6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // upstream free-running phase counter
   initial begin
      forever begin
         @(negedge clk);
         ucnt = ucnt + 7'd1;
      end
   end

   function automatic int lut_ref(input int k);
      real r;
      r = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      else return -$rtoi(-r + 0.5);
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   // monitor: advance the reference on each edge, then compare just after it
   always @(posedge clk) begin : mon
      int k;
      int exp_out;
      int rem;
      bit stb;
      bit acc;
      bit exp_done;
      bit new_bit;
      logic [7:0] w;
      if (!reset_n) begin
         mdl_q.delete();
         mdl_run   = 1'b0;
         mdl_bit   = 1'b0;
         mdl_pos   = 0;
         mdl_ready = 1'b1;
         clk1_prev = 1'b0;
      end else begin
         stb       = clk1 && !clk1_prev;
         clk1_prev = clk1;
         k         = int'(count[5:0]);
         exp_out   = 0;
         if (mdl_run) exp_out = mdl_bit ? -lut_ref(k) : lut_ref(k);
         acc       = din_valid && mdl_ready;
         w         = din;
         exp_done  = 1'b0;
         new_bit   = 1'b0;
         if (stb) begin
            if (mdl_run && mdl_pos < 7) begin
               if (mdl_q.size() > 0) mdl_bit = mdl_q.pop_front();
               mdl_pos++;
               new_bit = 1'b1;
            end else begin
               exp_done = mdl_run;
               if (mdl_q.size() > 0) begin
                  mdl_bit = mdl_q.pop_front();
                  mdl_pos = 0;
                  mdl_run = 1'b1;
                  new_bit = 1'b1;
               end else begin
                  mdl_run = 1'b0;
               end
            end
         end
         if (acc) begin
            for (int i = 7; i >= 0; i--) mdl_q.push_back(w[i]);
         end
         rem       = mdl_run ? (7 - mdl_pos) : 0;
         mdl_ready = (mdl_q.size() <= rem);
         #1;
         check("bpsk_out", int'(bpsk_out), exp_out);
         check("sym_active", int'(sym_active), int'(mdl_run));
         check("byte_done", int'(byte_done), int'(exp_done));
         check("din_ready", int'(din_ready), int'(mdl_ready));
         if (new_bit) check("tx_bit", int'(tx_bit), int'(mdl_bit));
      end
   end

   task automatic send(input logic [7:0] w);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      din       = w;
      din_valid = 1'b1;
      for (int i = 0; i < 600 && !ok; i++) begin
         if (din_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      din_valid = 1'b0;
      check("send_accept", int'(ok), 1);
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (!mdl_run && mdl_q.size() == 0) ok = 1'b1;
      end
      check("wait_idle", int'(ok), 1);
   endtask

   task automatic wait_pos(input int pos, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (mdl_run && mdl_pos == pos) ok = 1'b1;
      end
      check("wait_pos", int'(ok), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bpsk"}, int'(bpsk_out), 0);
      check({tag, "_tx_bit"}, int'(tx_bit), 0);
      check({tag, "_sym_active"}, int'(sym_active), 0);
      check({tag, "_byte_done"}, int'(byte_done), 0);
      check({tag, "_din_ready"}, int'(din_ready), 1);
   endtask

   initial begin
      reset_n   = 1'b0;
      din       = 8'h00;
      din_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      reset_n = 1'b1;

      // five idle symbol periods with no data
      repeat (640) @(negedge clk);
      check("idle_sym_active", int'(sym_active), 0);
      check("idle_bpsk", int'(bpsk_out), 0);

      // single word, holding register fills on the cycle after accept
      send(8'hA5);
      check("a5_ready_drop", int'(din_ready), 0);
      wait_idle(2000);
      repeat (3) @(negedge clk);
      check("a5_end_bpsk", int'(bpsk_out), 0);

      // back-to-back words; the second waits for the draining strobe
      send(8'hFF);
      send(8'h00);
      wait_idle(4000);

      // reset in the middle of a word
      send(8'hC3);
      wait_pos(4, 2000);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (400) @(negedge clk);
      check("post_rst_idle", int'(sym_active), 0);

      // a couple of random words to close
      send(8'($urandom_range(0, 255)));
      send(8'($urandom_range(0, 255)));
      wait_idle(4000);
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
